// File: rtl/drbg_pkg.sv
// Shared state encoding and reseed-interval default for the DRBG controller and its engines.
// Types and constants only; no logic.
package drbg_pkg;

    typedef enum logic [2:0] {
        UNINST,
        INST,
        READY,
        RESEED,
        GEN,
        FAULT
    } drbg_state_e;

    localparam logic [15:0] RESEED_INTERVAL_DEFAULT = 16'd1000;

endpackage

// File: rtl/drbg_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer and decides when a grant is consumed.
module drbg_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W:0] pos;
    logic           found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(N_REQ)) begin
                pos = pos - (IDX_W+1)'(N_REQ);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found                 = 1'b1;
                idx                   = pos[IDX_W-1:0];
                gnt[pos[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/drbg_ctrl.sv
// DRBG lifecycle FSM: arbitrates requesters onto one DRBG, sequences instantiate/reseed/generate engines.
// Registered outputs; request to response is 3 cycles (generate) or 5 (reseed+generate) with zero-latency engines.
module drbg_ctrl
    import drbg_pkg::*;
#(
    parameter int               N_REQ           = 4,
    parameter int               CNT_W           = 16,
    parameter logic [CNT_W-1:0] RESEED_INTERVAL = CNT_W'(RESEED_INTERVAL_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_req,
    input  logic             uninst_req,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_pr,
    output logic [N_REQ-1:0] req_ready,
    output logic [N_REQ-1:0] rsp_valid,
    output logic             rsp_error,
    output logic             inst_start,
    output logic             reseed_start,
    output logic             gen_start,
    input  logic             inst_done,
    input  logic             reseed_done,
    input  logic             gen_done,
    input  logic             inst_error,
    input  logic             reseed_error,
    input  logic             gen_error,
    input  logic             catastrophic,
    output logic             instantiated,
    output logic             fault,
    output logic [CNT_W-1:0] reseed_counter
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    drbg_state_e      state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] g_idx;
    logic [N_REQ-1:0] g_oh;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;

    drbg_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= UNINST;
            rr_ptr         <= '0;
            g_idx          <= '0;
            g_oh           <= '0;
            req_ready      <= '0;
            rsp_valid      <= '0;
            rsp_error      <= 1'b0;
            inst_start     <= 1'b0;
            reseed_start   <= 1'b0;
            gen_start      <= 1'b0;
            instantiated   <= 1'b0;
            fault          <= 1'b0;
            reseed_counter <= '0;
        end else begin
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_error    <= 1'b0;
            inst_start   <= 1'b0;
            reseed_start <= 1'b0;
            gen_start    <= 1'b0;

            // Catastrophic errors override every transition and drop any in-flight request.
            if (catastrophic) begin
                state          <= FAULT;
                fault          <= 1'b1;
                instantiated   <= 1'b0;
                reseed_counter <= '0;
            end else begin
                case (state)
                    UNINST: begin
                        if (inst_req) begin
                            state      <= INST;
                            inst_start <= 1'b1;
                        end
                    end
                    INST: begin
                        if (inst_done) begin
                            if (inst_error) begin
                                state          <= UNINST;
                                reseed_counter <= '0;
                            end else begin
                                state          <= READY;
                                instantiated   <= 1'b1;
                                reseed_counter <= CNT_W'(1);
                            end
                        end
                    end
                    READY: begin
                        if (uninst_req) begin
                            state          <= UNINST;
                            instantiated   <= 1'b0;
                            reseed_counter <= '0;
                        end else if (arb_any) begin
                            g_idx     <= arb_idx;
                            g_oh      <= arb_gnt;
                            req_ready <= arb_gnt;
                            if ((|(req_pr & arb_gnt)) || (reseed_counter > RESEED_INTERVAL)) begin
                                state        <= RESEED;
                                reseed_start <= 1'b1;
                            end else begin
                                state     <= GEN;
                                gen_start <= 1'b1;
                            end
                        end
                    end
                    RESEED: begin
                        if (reseed_done) begin
                            if (reseed_error) begin
                                state     <= READY;
                                rsp_valid <= g_oh;
                                rsp_error <= 1'b1;
                            end else begin
                                state          <= GEN;
                                gen_start      <= 1'b1;
                                reseed_counter <= CNT_W'(1);
                            end
                        end
                    end
                    GEN: begin
                        if (gen_done) begin
                            state     <= READY;
                            rsp_valid <= g_oh;
                            rsp_error <= gen_error;
                            if (!gen_error && (reseed_counter != '1)) begin
                                reseed_counter <= reseed_counter + CNT_W'(1);
                            end
                            rr_ptr <= (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + IDX_W'(1);
                        end
                    end
                    FAULT: begin
                        fault <= 1'b1;
                    end
                    default: begin
                        state <= UNINST;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_drbg_ctrl.sv
// Directed bench for drbg_ctrl: two instances (default interval and interval 2), scoreboard of grants/responses.
module tb_drbg_ctrl;

    localparam int N  = 4;
    localparam int CW = 16;

    typedef struct {
        int idx;
        bit err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;

    logic          inst_req     [2];
    logic          uninst_req   [2];
    logic [N-1:0]  req_valid    [2];
    logic [N-1:0]  req_pr       [2];
    logic [N-1:0]  req_ready    [2];
    logic [N-1:0]  rsp_valid    [2];
    logic          rsp_error    [2];
    logic          inst_start   [2];
    logic          reseed_start [2];
    logic          gen_start    [2];
    logic          inst_done    [2];
    logic          reseed_done  [2];
    logic          gen_done     [2];
    logic          inst_error   [2];
    logic          reseed_error [2];
    logic          gen_error    [2];
    logic          catastrophic [2];
    logic          instantiated [2];
    logic          fault        [2];
    logic [CW-1:0] reseed_counter [2];

    bit inst_err_mode   = 1'b0;
    bit reseed_err_mode = 1'b0;
    bit gen_err_mode    = 1'b0;

    int sel = 0;
    int total = 0;
    int bad = 0;

    rsp_t exp_rsp[$];
    int   exp_gnt[$];
    int   start_log[$];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [2:0] ip = '0;
        logic       rp = 1'b0;
        logic       gp = 1'b0;

        // Engine stand-ins: instantiate answers 3 cycles after start, reseed/generate 1 cycle after.
        always @(posedge clk) begin
            ip <= {ip[1:0], inst_start[k]};
            rp <= reseed_start[k];
            gp <= gen_start[k];
        end

        assign inst_done[k]    = ip[2];
        assign reseed_done[k]  = rp;
        assign gen_done[k]     = gp;
        assign inst_error[k]   = ip[2] & inst_err_mode;
        assign reseed_error[k] = rp & reseed_err_mode;
        assign gen_error[k]    = gp & gen_err_mode;

        drbg_ctrl #(
            .N_REQ           (N),
            .CNT_W           (CW),
            .RESEED_INTERVAL ((k == 0) ? 16'd1000 : 16'd2)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .inst_req       (inst_req[k]),
            .uninst_req     (uninst_req[k]),
            .req_valid      (req_valid[k]),
            .req_pr         (req_pr[k]),
            .req_ready      (req_ready[k]),
            .rsp_valid      (rsp_valid[k]),
            .rsp_error      (rsp_error[k]),
            .inst_start     (inst_start[k]),
            .reseed_start   (reseed_start[k]),
            .gen_start      (gen_start[k]),
            .inst_done      (inst_done[k]),
            .reseed_done    (reseed_done[k]),
            .gen_done       (gen_done[k]),
            .inst_error     (inst_error[k]),
            .reseed_error   (reseed_error[k]),
            .gen_error      (gen_error[k]),
            .catastrophic   (catastrophic[k]),
            .instantiated   (instantiated[k]),
            .fault          (fault[k]),
            .reseed_counter (reseed_counter[k])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Output monitor for the selected instance: every grant/response must match the scoreboard.
    always @(negedge clk) begin : mon
        rsp_t r;
        if (!rst) begin
            if (req_ready[sel] != '0) begin
                if (exp_gnt.size() == 0) chk("unexpected_ready", 32'(req_ready[sel]), 32'd0);
                else chk("grant", 32'(req_ready[sel]), 32'(1) << exp_gnt.pop_front());
            end
            if (rsp_valid[sel] != '0) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid[sel]), 32'd0);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_idx", 32'(rsp_valid[sel]), 32'(1) << r.idx);
                    chk("rsp_err", 32'(rsp_error[sel]), 32'(r.err));
                end
            end
            if (inst_start[sel] || reseed_start[sel] || gen_start[sel]) begin
                chk("one_start", 32'($countones({inst_start[sel], reseed_start[sel], gen_start[sel]})), 32'd1);
                if (inst_start[sel])   start_log.push_back(1);
                if (reseed_start[sel]) start_log.push_back(2);
                if (gen_start[sel])    start_log.push_back(3);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_inst();
        step();
        inst_req[sel] = 1'b1;
        step();
        inst_req[sel] = 1'b0;
    endtask

    task automatic wait_inst();
        int n = 0;
        while (instantiated[sel] !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("inst_up", 32'(instantiated[sel]), 32'd1);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (req_ready[sel] == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_seen", 32'(n < 40), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_gnt.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_rsp.size() + exp_gnt.size()), 32'd0);
    endtask

    task automatic do_req(input int idx, input bit pr, input bit err);
        rsp_t r;
        r.idx = idx;
        r.err = err;
        exp_gnt.push_back(idx);
        exp_rsp.push_back(r);
        step();
        req_valid[sel][idx] = 1'b1;
        req_pr[sel][idx]    = pr;
        wait_ready();
        req_valid[sel] = '0;
        req_pr[sel]    = '0;
        drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rsp_t r;
        int   n;
        int   c;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            inst_req[k]     = 1'b0;
            uninst_req[k]   = 1'b0;
            req_valid[k]    = '0;
            req_pr[k]       = '0;
            catastrophic[k] = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("rst_inst", 32'(instantiated[0]), 32'd0);
        chk("rst_fault", 32'(fault[0]), 32'd0);
        chk("rst_cnt", 32'(reseed_counter[0]), 32'd0);
        chk("rst_ready", 32'(req_ready[0]), 32'd0);
        chk("rst_rsp", 32'(rsp_valid[0]), 32'd0);
        step();
        rst = 1'b0;

        // Instantiate failure leaves the DRBG uninstantiated.
        sel = 0;
        inst_err_mode = 1'b1;
        pulse_inst();
        idle(8);
        chk("inst_err_inst", 32'(instantiated[0]), 32'd0);
        chk("inst_err_cnt", 32'(reseed_counter[0]), 32'd0);
        chk("inst_err_log", 32'(start_log.size()), 32'd1);
        inst_err_mode = 1'b0;

        // Retry succeeds, which also shows the failed attempt returned to UNINST.
        pulse_inst();
        wait_inst();
        chk("inst_cnt", 32'(reseed_counter[0]), 32'd1);

        // Round-robin with all four requesting.
        for (int i = 0; i < 5; i++) begin
            exp_gnt.push_back(i % N);
            r.idx = i % N;
            r.err = 1'b0;
            exp_rsp.push_back(r);
        end
        step();
        req_valid[0] = 4'b1111;
        n = 0;
        c = 0;
        while (n < 5 && c < 200) begin
            @(negedge clk);
            c++;
            if (req_ready[0] != '0) n++;
        end
        req_valid[0] = '0;
        chk("rr_grants", 32'(n), 32'd5);
        drain();
        chk("rr_cnt", 32'(reseed_counter[0]), 32'd6);

        // Prediction resistance forces a reseed before the generate.
        start_log.delete();
        do_req(2, 1'b1, 1'b0);
        chk("pr_log_n", 32'(start_log.size()), 32'd2);
        chk("pr_log0", 32'(start_log[0]), 32'd2);
        chk("pr_log1", 32'(start_log[1]), 32'd3);
        chk("pr_cnt", 32'(reseed_counter[0]), 32'd2);

        // Reseed failure answers with an error and skips the generate.
        start_log.delete();
        reseed_err_mode = 1'b1;
        do_req(2, 1'b1, 1'b1);
        reseed_err_mode = 1'b0;
        chk("rserr_log_n", 32'(start_log.size()), 32'd1);
        chk("rserr_log0", 32'(start_log[0]), 32'd2);
        chk("rserr_cnt", 32'(reseed_counter[0]), 32'd2);

        // Generate failure: error response, counter held.
        gen_err_mode = 1'b1;
        do_req(3, 1'b0, 1'b1);
        gen_err_mode = 1'b0;
        chk("generr_cnt", 32'(reseed_counter[0]), 32'd2);

        // Uninstantiate wins over a simultaneous request.
        step();
        uninst_req[0]   = 1'b1;
        req_valid[0][1] = 1'b1;
        step();
        uninst_req[0] = 1'b0;
        idle(5);
        req_valid[0] = '0;
        chk("uninst_inst", 32'(instantiated[0]), 32'd0);
        chk("uninst_cnt", 32'(reseed_counter[0]), 32'd0);

        // Automatic reseed on the interval-2 instance.
        sel = 1;
        start_log.delete();
        pulse_inst();
        wait_inst();
        chk("ar_inst_cnt", 32'(reseed_counter[1]), 32'd1);
        do_req(0, 1'b0, 1'b0);
        do_req(0, 1'b0, 1'b0);
        chk("ar_cnt_pre", 32'(reseed_counter[1]), 32'd3);
        start_log.delete();
        do_req(0, 1'b0, 1'b0);
        chk("ar_log_n", 32'(start_log.size()), 32'd2);
        chk("ar_log0", 32'(start_log[0]), 32'd2);
        chk("ar_log1", 32'(start_log[1]), 32'd3);
        chk("ar_cnt", 32'(reseed_counter[1]), 32'd2);

        // Catastrophic fault during a generate.
        sel = 0;
        pulse_inst();
        wait_inst();
        exp_gnt.push_back(1);
        step();
        req_valid[0][1] = 1'b1;
        wait_ready();
        req_valid[0]    = '0;
        catastrophic[0] = 1'b1;
        @(negedge clk);
        chk("fault_set", 32'(fault[0]), 32'd1);
        chk("fault_inst", 32'(instantiated[0]), 32'd0);
        chk("fault_cnt", 32'(reseed_counter[0]), 32'd0);
        step();
        catastrophic[0] = 1'b0;
        req_valid[0]    = 4'b1111;
        idle(10);
        req_valid[0] = '0;
        chk("fault_sticky", 32'(fault[0]), 32'd1);
        chk("fault_noresp", 32'(exp_gnt.size() + exp_rsp.size()), 32'd0);

        rst = 1'b1;
        idle(2);
        @(negedge clk);
        chk("post_rst_fault", 32'(fault[0]), 32'd0);
        chk("post_rst_cnt", 32'(reseed_counter[0]), 32'd0);
        rst = 1'b0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drbg_ctrl.md
# drbg_ctrl

Lifecycle controller and requester arbiter for the DRBG core. It shares one DRBG instance between `N_REQ` requesters using round-robin arbitration. It sequences the instantiate, reseed and generate engines through single-cycle start pulses and done handshakes, and maintains the reseed counter. It also enforces the automatic-reseed and prediction-resistance rules, and latches catastrophic faults.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `CNT_W`, 16: reseed counter width.
- `RESEED_INTERVAL`, 16'd1000: maximum number of generates between reseeds.

Ports:
- `clk` in, 1: single clock domain.
- `rst` in, 1: asynchronous, active-high reset.
- `inst_req` in, 1: request instantiation; sampled only in UNINST.
- `uninst_req` in, 1: request uninstantiation; sampled only in READY.
- `req_valid` in, `N_REQ`: per-requester generate request; held until accepted.
- `req_pr` in, `N_REQ`: prediction resistance wanted; qualified by `req_valid`.
- `req_ready` out, `N_REQ`: one-hot acceptance pulse.
- `rsp_valid` out, `N_REQ`: one-hot completion pulse.
- `rsp_error` out, 1: qualifies `rsp_valid`; 1 means the request failed.
- `inst_start`, `reseed_start`, `gen_start` out, 1 each: engine start pulses.
- `inst_done`, `reseed_done`, `gen_done` in, 1 each: engine completion pulses.
- `inst_error`, `reseed_error`, `gen_error` in, 1 each: engine error, valid with the matching done.
- `catastrophic` in, 1: catastrophic error from any engine, level.
- `instantiated` out, 1: high in READY, RESEED and GEN.
- `fault` out, 1: sticky catastrophic flag.
- `reseed_counter` out, `CNT_W`: current counter value.

## Operation
- Reset values: state UNINST, all outputs 0, round-robin pointer 0.
- All outputs are registered.

State machine, one state at a time:
- **UNINST**
  - `inst_req` → INST, with an `inst_start` pulse.
  - `req_valid` is not accepted; `req_ready` stays 0.
- **INST**, waiting for `inst_done`:
  - `inst_done` with `!inst_error` → READY, counter set to 1.
  - `inst_done` with `inst_error` → UNINST, counter 0.
- **READY**
  - Priority: `uninst_req` first. It moves to UNINST, clears the counter, and no request is accepted that cycle.
  - Otherwise, if any `req_valid`, the round-robin arbiter picks grant `g`, the first valid index at or after the pointer (wrapping).
  - The grant is latched, followed by a `req_ready[g]` pulse.
  - If `req_pr[g]` or counter > `RESEED_INTERVAL` → RESEED, with a `reseed_start` pulse.
  - Otherwise → GEN, with a `gen_start` pulse.
- **RESEED**, waiting for `reseed_done`:
  - Success → counter set to 1, then GEN with a `gen_start` pulse.
  - Error → `rsp_valid[g]` with `rsp_error`=1, generate skipped, counter unchanged, → READY.
- **GEN**, waiting for `gen_done`:
  - Success → counter +1, saturating at all-ones; `rsp_valid[g]` with `rsp_error`=0.
  - Error → counter unchanged; `rsp_valid[g]` with `rsp_error`=1.
  - Either way → READY, and the pointer moves to (g+1) mod `N_REQ`.
- **FAULT**
  - Entered from any state when `catastrophic`=1. This takes priority over every other transition that cycle.
  - Sets `fault`=1 and clears the counter.
  - Start pulses, `req_ready` and `rsp_valid` are all suppressed.
  - An in-flight request gets no response.
  - Exit is by `rst` only.

Other rules:
- Done and error inputs arriving in a state that is not waiting for them are ignored.
- At most one start pulse is high in any cycle.
- A requester that drops `req_valid` before `req_ready` is legal; it is simply not granted.
- Reset mid-operation aborts immediately: outputs return to reset values and engine done pulses are ignored afterwards.

## Timing
- `req_valid` seen in READY at cycle t → `req_ready[g]` and the start pulse both at t+1.
- Engine done at cycle d → `rsp_valid` at d+1. State is READY at d+1, so the earliest next `req_ready` is d+2.
- Reseed done at d → `gen_start` at d+1.
- `inst_done` at d → `instantiated`=1 at d+1.
- `catastrophic` at c → `fault`=1 at c+1.
- Request-to-response latency with zero-latency engines:
  - Generate only: 3 cycles.
  - Reseed plus generate: 5 cycles.

## Structure
- `drbg_pkg` holds:
  - the state enum (UNINST, INST, READY, RESEED, GEN, FAULT);
  - the default `RESEED_INTERVAL` constant, shared with the engines' counter checks.
- Sub-module `drbg_rr_arbiter`:
  - inputs: `N_REQ`-wide request vector and pointer;
  - outputs: one-hot grant, encoded index and any-valid;
  - combinational.
- The FSM, counter and response logic live in `drbg_ctrl`.

## Test plan
- **Instantiate flow:** pulse `inst_req`, return `inst_done` 3 cycles later → `instantiated`=1, `reseed_counter`=1. Repeat with `inst_error`=1 → stays UNINST, counter 0.
- **Round-robin fairness:** `req_valid`=4'b1111 held continuously, engines done in 1 cycle → grants 0,1,2,3,0 in order, each `rsp_valid` with `rsp_error`=0, counter reaches 6.
- **Automatic reseed:** `RESEED_INTERVAL`=2, three generates → third request issues `reseed_start` before `gen_start`, and the counter reads 2 after it.
- **Prediction resistance:** `req_pr[2]`=1 with counter 1 → reseed then generate; a `reseed_error` instead gives `rsp_valid[2]` with `rsp_error`=1, no `gen_start`, counter unchanged.
- **Catastrophic fault:** `catastrophic` during GEN → `fault`=1 the next cycle, no `rsp_valid`, later `req_valid` never accepted until `rst`.
- **Uninstantiate priority:** `uninst_req` and `req_valid[1]` in the same READY cycle → no `req_ready`, UNINST, counter 0.
